// File: rtl/restoring_div_pkg.sv
// rtl/restoring_div_pkg.sv - shared FSM state type and default widths for the restoring divider
package restoring_div_pkg;

   localparam int DEF_DIVIDEND_W = 16;
   localparam int DEF_DIVISOR_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step: trial subtract and quotient bit decision
module div_step #(
   parameter int DIVISOR_W = 8
) (
   input  logic [DIVISOR_W:0]   part_rem,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W-1:0] next_rem,
   output logic                 q_bit
);

   always_comb begin
      q_bit    = (part_rem >= {1'b0, divisor});
      // On a successful subtract the true difference is below the divisor, so the
      // modular DIVISOR_W-bit difference is exact.
      next_rem = q_bit ? (part_rem[DIVISOR_W-1:0] - divisor) : part_rem[DIVISOR_W-1:0];
   end

endmodule

// File: rtl/restoring_div_16b.sv
// rtl/restoring_div_16b.sv - sequential restoring divider, one quotient bit per cycle, MSB first
// Optional result self-check is enabled by defining RESTORING_DIV_SELFCHECK_EN.
module restoring_div_16b
   import restoring_div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  chk_err
);

   localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   div_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  dbz_q, dbz_d;
   logic                  done_q, done_d;

   logic [DIVISOR_W:0]    part_rem;
   logic [DIVISOR_W-1:0]  step_rem;
   logic                  step_q;

   // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
   assign part_rem = {rem_q, dvd_q[DIVIDEND_W-1]};

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .part_rem (part_rem),
      .divisor  (dsr_q),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      rem_d       = rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dsr_d   = divisor;
               rem_d   = '0;
               cnt_d   = CNT_W'(DIVIDEND_W - 1);
               state_d = (divisor == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
            if (cnt_q == '0) begin
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dsr_q == '0) begin
               quotient_d  = '1;
               remainder_d = dvd_q[DIVISOR_W-1:0];
               dbz_d       = 1'b1;
            end else begin
               quotient_d  = dvd_q;
               remainder_d = rem_q;
               dbz_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         rem_q       <= rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

`ifdef RESTORING_DIV_SELFCHECK_EN
   localparam int PW = DIVIDEND_W + DIVISOR_W;

   logic [DIVIDEND_W-1:0] dvd_orig_q, dvd_orig_d;
   logic                  chk_err_q, chk_err_d;
   logic [PW-1:0]         recon;
   logic                  chk_fail;

   // In FINISH dvd_q already holds the quotient, so the original dividend is kept aside.
   always_comb begin
      recon      = PW'(dvd_q) * PW'(dsr_q) + PW'(rem_q);
      chk_fail   = (recon != PW'(dvd_orig_q)) || (rem_q >= dsr_q);
      dvd_orig_d = dvd_orig_q;
      chk_err_d  = chk_err_q;
      if ((state_q == IDLE) && start) begin
         dvd_orig_d = dividend;
      end
      if (state_q == FINISH) begin
         chk_err_d = (dsr_q == '0) ? 1'b0 : chk_fail;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_orig_q <= '0;
         chk_err_q  <= 1'b0;
      end else begin
         dvd_orig_q <= dvd_orig_d;
         chk_err_q  <= chk_err_d;
      end
   end

   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_div_16b.sv
// tb/tb_restoring_div_16b.sv - directed and random checks of restoring_div_16b against an arithmetic model
module tb_restoring_div_16b;

   localparam int DW = 16;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy, done, div_by_zero, chk_err;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] last_q = '0;
   logic [VW-1:0] last_r = '0;

   always #5 clk = ~clk;

   restoring_div_16b #(
      .DIVIDEND_W (DW),
      .DIVISOR_W  (VW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .chk_err     (chk_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled by the next rising edge (edge 0).
   // Sample k is taken just before edge k. Optionally pulses start with other
   // operands at sample pulse_at, which must be ignored.
   task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input int pulse_at, input logic [DW-1:0] pa, input logic [VW-1:0] pb);
      logic [DW-1:0] eq;
      logic [VW-1:0] er;
      logic [DW-1:0] wide_r;
      logic          edz;
      int            el;
      int            lat;
      if (b == '0) begin
         eq  = '1;
         er  = a[VW-1:0];
         edz = 1'b1;
         el  = 2;
      end else begin
         eq     = a / {8'd0, b};
         wide_r = a % {8'd0, b};
         er     = wide_r[VW-1:0];
         edz    = 1'b0;
         el     = DW + 2;
      end
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            chk({tag, " busy_rise"}, busy, (b != '0));
            chk({tag, " done_width"}, done, 1'b0);
         end else if (k == pulse_at) begin
            chk({tag, " hold_q"}, quotient, last_q);
            chk({tag, " hold_r"}, remainder, last_r);
            start    = 1'b1;
            dividend = pa;
            divisor  = pb;
         end else if (k == pulse_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk);
      end
      start = 1'b0;
      chk({tag, " latency"}, lat, el);
      chk({tag, " quotient"}, quotient, eq);
      chk({tag, " remainder"}, remainder, er);
      chk({tag, " div_by_zero"}, div_by_zero, edz);
      chk({tag, " busy_at_done"}, busy, 1'b0);
      chk({tag, " chk_err"}, chk_err, 1'b0);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset quotient", quotient, 16'h0);
      chk("reset remainder", remainder, 8'h0);
      chk("reset div_by_zero", div_by_zero, 1'b0);
      chk("reset chk_err", chk_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      run_div("d7191_47", 16'd7191, 8'd47, 0, '0, '0);
      run_div("d65025_255", 16'd65025, 8'd255, 0, '0, '0);
      run_div("d1000_7", 16'd1000, 8'd7, 0, '0, '0);
      run_div("d1234_0", 16'd1234, 8'd0, 0, '0, '0);
      run_div("d1953_63", 16'd1953, 8'd63, 5, 16'd100, 8'd3);
      run_div("finish_start", 16'd40000, 8'd200, 17, 16'd9, 8'd2);
      @(posedge clk);
      @(negedge clk);
      chk("finish_start idle busy", busy, 1'b0);
      chk("finish_start idle done", done, 1'b0);

      // Abort mid-division with an asynchronous reset in RUN cycle 8.
      start    = 1'b1;
      dividend = 16'd50000;
      divisor  = 8'd77;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort quotient", quotient, 16'h0);
      chk("abort remainder", remainder, 8'h0);
      chk("abort div_by_zero", div_by_zero, 1'b0);
      chk("abort chk_err", chk_err, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("abort no done", done, 1'b0);
      end
      rst_n  = 1'b1;
      last_q = '0;
      last_r = '0;
      @(negedge clk);
      run_div("d65535_1", 16'd65535, 8'd1, 0, '0, '0);
      run_div("d0_1", 16'd0, 8'd1, 0, '0, '0);
      run_div("d200_255", 16'd200, 8'd255, 0, '0, '0);

      for (int i = 0; i < 1000; i++) begin
         logic [DW-1:0] ra;
         logic [VW-1:0] rb;
         ra = DW'($urandom_range(0, 65535));
         rb = VW'($urandom_range(1, 255));
         run_div("random", ra, rb, 0, '0, '0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
